// File: rtl/mandel_scheduler.sv
// Mandelbrot frame scheduler: walks a width x height pixel grid, drives an external
// two-phase z^2+c datapath per pixel and emits one iteration-count result per pixel.
module mandel_scheduler #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [BITS-1:0] x_start,
  input  logic [BITS-1:0] y_start,
  input  logic [BITS-1:0] step,
  input  logic [7:0]      width,
  input  logic [7:0]      height,
  input  logic [6:0]      max_iter,
  output logic            dp_phase,
  output logic [BITS-1:0] dp_x0,
  output logic [BITS-1:0] dp_y0,
  output logic [BITS-1:0] dp_x,
  output logic [BITS-1:0] dp_y,
  input  logic [BITS-1:0] dp_x_out,
  input  logic [BITS-1:0] dp_y_out,
  input  logic            dp_escape,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [6:0]      res_iter,
  output logic            res_escape,
  output logic [7:0]      res_col,
  output logic [7:0]      res_row,
  output logic            res_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {StIdle, StLoad, StIter, StEmit, StDone} state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;
  logic [BITS-1:0] x0_q, x0_d, y0_q, y0_d, x_q, x_d, y_q, y_d;
  logic [BITS-1:0] xs_q, xs_d, step_q, step_d;
  logic [7:0]      width_q, width_d, height_q, height_d;
  logic [7:0]      col_q, col_d, row_q, row_d;
  logic [6:0]      max_q, max_d, iter_q, iter_d;
  logic            esc_q, esc_d;
  logic            last_col, last_pix;

  assign last_col = (col_q == width_q - 8'd1);
  assign last_pix = last_col && (row_q == height_q - 8'd1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x_d      = x_q;
    y_d      = y_q;
    xs_d     = xs_q;
    step_d   = step_q;
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    max_d    = max_q;
    iter_d   = iter_q;
    esc_d    = esc_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          xs_d     = x_start;
          step_d   = step;
          width_d  = width;
          height_d = height;
          max_d    = max_iter;
          col_d    = 8'd0;
          row_d    = 8'd0;
          x0_d     = x_start;
          y0_d     = y_start;
          state_d  = (width == 8'd0 || height == 8'd0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        x_d     = x0_q;
        y_d     = y0_q;
        iter_d  = 7'd0;
        phase_d = 1'b0;
        state_d = StIter;
      end
      StIter: begin
        phase_d = ~phase_q;
        // Phase 1 is where the datapath result for the current z is valid.
        if (phase_q) begin
          if (dp_escape) begin
            esc_d   = 1'b1;
            state_d = StEmit;
          end else if (iter_q == max_q) begin
            esc_d   = 1'b0;
            state_d = StEmit;
          end else begin
            iter_d = iter_q + 7'd1;
            x_d    = dp_x_out;
            y_d    = dp_y_out;
          end
        end
      end
      StEmit: begin
        if (res_ready) begin
          if (last_pix) begin
            state_d = StDone;
          end else if (!last_col) begin
            col_d   = col_q + 8'd1;
            x0_d    = x0_q + step_q;
            state_d = StLoad;
          end else begin
            col_d   = 8'd0;
            row_d   = row_q + 8'd1;
            x0_d    = xs_q;
            y0_d    = y0_q - step_q;
            state_d = StLoad;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      phase_q  <= 1'b0;
      x0_q     <= '0;
      y0_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      xs_q     <= '0;
      step_q   <= '0;
      width_q  <= 8'd0;
      height_q <= 8'd0;
      col_q    <= 8'd0;
      row_q    <= 8'd0;
      max_q    <= 7'd0;
      iter_q   <= 7'd0;
      esc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xs_q     <= xs_d;
      step_q   <= step_d;
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      max_q    <= max_d;
      iter_q   <= iter_d;
      esc_q    <= esc_d;
    end
  end

  assign dp_phase   = phase_q;
  assign dp_x0      = x0_q;
  assign dp_y0      = y0_q;
  assign dp_x       = x_q;
  assign dp_y       = y_q;
  assign res_valid  = (state_q == StEmit);
  assign res_iter   = iter_q;
  assign res_escape = esc_q;
  assign res_col    = col_q;
  assign res_row    = row_q;
  assign res_last   = (state_q == StEmit) && last_pix;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: doc/mandel_scheduler.md
MANDEL_SCHEDULER -- requirements
Module: mandel_scheduler

Interface
REQ-001 SHALL have parameter BITS, default 16, meaning width of all fixed-point coordinates (signed, 3 integer bits, BITS-3 fraction bits).
REQ-002 SHALL have ports; clock and reset are listed first:
- clk  in  1  the single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame scan; sampled only in IDLE
- abort  in  1  terminate the scan
- x_start  in  BITS  left-column x0
- y_start  in  BITS  top-row y0
- step  in  BITS  pixel pitch
- width  in  8  columns per row
- height  in  8  rows per frame
- max_iter  in  7  iteration cap
- dp_phase  out  1  datapath phase
- dp_x0, dp_y0  out  BITS  current pixel c
- dp_x, dp_y  out  BITS  current z
- dp_x_out, dp_y_out  in  BITS  next z from the datapath
- dp_escape  in  1  datapath escape flag
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_iter  out  7  iteration count
- res_escape  out  1  pixel escaped
- res_col, res_row  out  8  pixel coordinates
- res_last  out  1  final pixel of the frame
- busy  out  1  state is not IDLE
- done  out  1  one-cycle end-of-frame pulse

Function
REQ-003 SHALL implement the states IDLE, LOAD, ITER, EMIT and DONE.
REQ-004 IDLE with start=1 SHALL capture x_start, y_start, step, width, height and max_iter; set col=row=0, dp_x0=x_start, dp_y0=y_start; and go to LOAD. If width=0 or height=0 it SHALL go to DONE instead.
REQ-005 Config inputs changing while busy SHALL have no effect on the scan in progress.
REQ-006 LOAD (1 cycle) SHALL set dp_x=dp_x0, dp_y=dp_y0, iter=0, dp_phase=0, then enter ITER.
REQ-007 In ITER, dp_phase SHALL toggle every cycle, starting at 0.
REQ-008 On an ITER cycle with dp_phase=1, escape and cap SHALL be checked in this priority order:
- dp_escape=1: go to EMIT with res_escape=1.
- else iter==max_iter: go to EMIT with res_escape=0.
- else: iter+1; dp_x<=dp_x_out; dp_y<=dp_y_out.
REQ-009 Iterations per pixel SHALL therefore cost exactly 2 cycles.
REQ-010 max_iter=0 SHALL emit iter=0 after one phase pair, with res_escape equal to dp_escape.
REQ-011 In EMIT, res_valid SHALL be 1, with res_iter, res_escape, res_col, res_row and res_last stable until res_valid&&res_ready.
REQ-012 res_last SHALL be 1 iff col==width-1 and row==height-1.
REQ-013 On handshake with res_last=1, the block SHALL go to DONE.
REQ-014 On handshake with col<width-1, it SHALL set col+1, dp_x0<=dp_x0+step, and go to LOAD.
REQ-015 On handshake with col==width-1, it SHALL set col=0, row+1, dp_x0<=x_start (captured), dp_y0<=dp_y0-step, and go to LOAD.
REQ-016 Coordinate add and subtract SHALL wrap modulo 2^BITS in two's complement, with no saturation.
REQ-017 DONE SHALL assert done for exactly 1 cycle, then enter IDLE; res_valid SHALL be 0 in DONE.
REQ-018 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with res_valid=0, without pulsing done; abort takes priority over a simultaneous handshake.
REQ-019 start asserted while busy SHALL be ignored.
REQ-020 res_valid SHALL be 0 in every state other than EMIT.
REQ-021 busy SHALL be 0 only in IDLE.

Reset
REQ-022 rst=1 at a clk edge SHALL force IDLE, dp_phase=0, res_valid=0, done=0, busy=0, iter=0, col=row=0 and res_*=0, regardless of state, including mid-ITER and mid-EMIT.
REQ-023 rst SHALL take priority over start and abort.
REQ-024 Coordinate registers SHALL also reset to 0.

Verification
REQ-025 SHALL cover: width=2, height=2, x_start=0xC000, y_start=0x1000, step=0x0800, max_iter=5, golden-model datapath, res_ready=1 -> 4 results in order (0,0),(1,0),(0,1),(1,1); dp_x0 at col 1 = 0xC800; dp_y0 at row 1 = 0x0800; res_last only on the 4th; done pulses once.
REQ-026 SHALL cover: datapath escape never asserted, max_iter=3 -> res_iter=3, res_escape=0, EMIT reached exactly 9 cycles after LOAD (LOAD 1 + 4 phase pairs).
REQ-027 SHALL cover: escape forced on the first phase=1 cycle -> res_iter=0, res_escape=1.
REQ-028 SHALL cover: res_ready held 0 for 10 cycles during EMIT -> res_valid and all res_* stable, no LOAD, then exactly one transfer.
REQ-029 SHALL cover: abort during ITER of pixel (1,0), and rst during EMIT in a separate run -> next cycle IDLE, busy=0, res_valid=0, done never pulses; a fresh start scans from (0,0).
REQ-030 SHALL cover: width=0 with start -> done pulses 1 cycle later, and no res_valid at any point.
